// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants and the add/subtract helper used by the
//               round-robin scheduler and the standalone datapath block.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Operation encoding carried on req_mode
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Default sizing for the scheduler
  localparam int c_def_width = 8;
  localparam int c_def_n_req = 4;

  // Widest operand the helper handles; callers zero-extend and truncate
  localparam int c_max_width = 64;

  // Subtract is A + two's complement of B; carry/borrow falls off the top
  // once the caller truncates to its own width.
  function automatic logic [c_max_width-1:0] addsub(
    input logic [c_max_width-1:0] a,
    input logic [c_max_width-1:0] b,
    input logic                   mode
  );
    if (mode == MODE_SUB) begin
      return a + (~b + {{(c_max_width-1){1'b0}}, 1'b1});
    end
    return a + b;
  endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches from
//               last_grant+1 upward, wrapping modulo N; the first active
//               request wins. Grant is suppressed when enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    w_found   = 1'b0;
    w_cand    = '0;
    grant_idx = '0;
    grant     = '0;
    for (int off = 1; off <= N; off++) begin
      w_cand = IDW'((int'(last_grant) + off) % N);
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        grant_idx = w_cand;
      end
    end
    if (w_found && enable) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : addsub_rr_scheduler
// Description : One shared add/subtract unit serving N_REQ requesters in
//               round-robin order. The winning operation is computed in the
//               accept cycle and held in a single-entry response register,
//               tagged with the requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_rr_scheduler
  import addsub_pkg::*;
#(
  parameter  int N_REQ = c_def_n_req,
  parameter  int WIDTH = c_def_width,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            busy_cnt
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [ID_W-1:0]  r_rsp_id;
  logic [ID_W-1:0]  r_last_grant;
  logic [15:0]      r_busy_cnt;

  logic             w_can_accept;
  logic             w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_mode;
  logic [WIDTH-1:0] w_result;

  // Slot is free when empty or being drained in this same cycle
  assign w_can_accept = !r_rsp_valid || rsp_ready;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .enable     (w_can_accept),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // Grant only ever lands on a valid requester, so ready doubles as handshake
  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  // Operand mux for the current arbitration winner
  always_comb begin
    w_a    = req_a[w_grant_idx*WIDTH +: WIDTH];
    w_b    = req_b[w_grant_idx*WIDTH +: WIDTH];
    w_mode = req_mode[w_grant_idx];
  end

  assign w_result = WIDTH'(addsub(c_max_width'(w_a), c_max_width'(w_b), w_mode));

  // Response register: load on accept (also when draining), clear on bare drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_result;
      r_rsp_id     <= w_grant_idx;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Round-robin pointer; reset to the top index so requester 0 leads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_accept) begin
      r_last_grant <= w_grant_idx;
    end
  end

  // Accepted-operation counter, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (w_accept && (r_busy_cnt != c_cnt_max)) begin
      r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy_cnt   = r_busy_cnt;

endmodule : addsub_rr_scheduler
`default_nettype wire

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
Shares one WIDTH-bit add/subtract unit among N_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair and mode over a valid/ready handshake.
- The winner's operation is computed and held in a single-entry output register.
- The result is returned on a valid/ready response channel, tagged with the requester ID.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, operand/result width in bits
ID_W, $clog2(N_REQ), width of requester ID tag (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_mode  in  N_REQ  0 = add (A+B), 1 = subtract (A-B)
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  downstream accepts response
rsp_result  out  WIDTH  result, modulo 2^WIDTH
rsp_id  out  ID_W  index of requester that issued the result
busy_cnt  out  16  count of accepted operations, saturating at 16'hFFFF

Behaviour:
- Reset values (async assert):
  - rsp_valid=0, rsp_result=0, rsp_id=0, busy_cnt=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-operation discards any held result; no response is emitted for it.
- can_accept = !rsp_valid || rsp_ready. The output register is empty, or is being drained this cycle.
- Arbitration is combinational. Search order is last_grant+1, +2, ... wrapping modulo N_REQ. The first i with req_valid[i]=1 is the candidate.
- req_ready[i] = (i == candidate) && can_accept. req_ready is never asserted for a requester with req_valid=0.
- Accept (handshake) at cycle T, when req_valid[i] && req_ready[i]:
  - rsp_result <= req_a_i + (req_mode_i ? (~req_b_i + 1) : req_b_i), truncated to WIDTH. Carry/borrow is dropped.
  - rsp_id <= i, rsp_valid <= 1 at T+1. Latency is exactly 1 cycle.
  - last_grant <= i.
  - busy_cnt increments by 1 unless already 16'hFFFF.
- Simultaneous drain and accept in the same cycle: the new result replaces the old, and rsp_valid stays 1. This gives full throughput of 1 op/cycle.
- Drain without accept: rsp_valid <= 0. rsp_result and rsp_id hold their last values.
- rsp_valid=1 && rsp_ready=0: all req_ready=0. Response outputs are held stable and last_grant is unchanged.
- No request valid: last_grant unchanged and no state change except draining.
- Requesters must hold req_a/req_b/req_mode stable while req_valid=1 and not accepted. The block does not check this.
- Subtract wrap-around: 8'h00 - 8'h01 = 8'hFF. Add overflow: 8'hFF + 8'h01 = 8'h00.
- Only state: output register, last_grant, busy_cnt. No FSM beyond the rsp_valid EMPTY/FULL bit.

Decomposition:
- Shared package addsub_pkg:
  - MODE_ADD=1'b0, MODE_SUB=1'b1.
  - Default WIDTH/N_REQ localparams.
  - Function addsub(a,b,mode) returning the WIDTH-bit result, shared with the standalone datapath block.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant, grant index.
  - Purely combinational. The pointer register stays in addsub_rr_scheduler.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=8'h12, b=8'h34, mode=0 -> req_ready=4'b0001 same cycle; next cycle rsp_valid=1, rsp_result=8'h46, rsp_id=0, busy_cnt=1.
- Round-robin fairness: all four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one rsp per cycle; busy_cnt=5 after 5 cycles.
- Backpressure: rsp_ready=0 with result held, req_valid=4'b1111 -> req_ready=0 and rsp_result/rsp_id stable for 3 cycles. Release rsp_ready -> same-cycle accept of the next requester in RR order, with no bubble.
- Arithmetic wrap: mode=1, a=8'h00, b=8'h01 -> 8'hFF. mode=0, a=8'hFF, b=8'h01 -> 8'h00. mode=1, a=8'h80, b=8'h80 -> 8'h00.
- Pointer skip: last_grant=1, req_valid=4'b0011 -> grant 0 (wraps past 2,3), then grant 1.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 -> rsp_valid=0, busy_cnt=0 immediately. After deassert, requester 0 wins over 3 when both are valid.
